// File: rtl/switch_pkg.sv
// Shared state encoding and default sizing for switch_core and its arbiter.
package switch_pkg;
    localparam int AW_DEV_DEF = 2;
    localparam int DW_DEF     = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        HOLD
    } state_e;
endpackage

// File: rtl/rr_arb.sv
// Round-robin pick among requesters, searching from ptr+1 modulo N; combinational.
// No backpressure: the caller samples the result only when it is ready to grant.
module rr_arb
    import switch_pkg::*;
#(
    parameter int AW = AW_DEV_DEF,
    parameter int N  = 1 << AW
) (
    input  logic [N-1:0]  rqt,
    input  logic [AW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [AW-1:0] idx
);
    logic          found;
    logic [AW-1:0] cand;

    always_comb begin
        gnt_oh = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        // i == N wraps back to ptr itself, so the last winner has lowest priority
        for (int i = 1; i <= N; i++) begin
            cand = ptr + AW'(i);
            if (!found && rqt[cand]) begin
                found        = 1'b1;
                idx          = cand;
                gnt_oh[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/switch_core.sv
// Single-transfer crossbar: grant 1 cycle after request, FIFO write 2 cycles after; SWITCH_CORE_STATS_EN adds pkt_cnt.
// Backpressure: a full destination holds the transfer in WRITE; the source holds grant via validtx.
module switch_core
    import switch_pkg::*;
#(
    parameter int  AW_DEV = AW_DEV_DEF,
    parameter int  DW     = DW_DEF,
    localparam int N      = 1 << AW_DEV
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         rqt,
    input  logic [N-1:0]         validtx,
    input  logic [N*DW-1:0]      dat_i,
    input  logic [N*AW_DEV-1:0]  adr_i,
    input  logic [N-1:0]         full_array,
    output logic [N-1:0]         gnt,
    output logic [DW-1:0]        fifo_o,
    output logic [N-1:0]         wen
`ifdef SWITCH_CORE_STATS_EN
    ,
    output logic [15:0]          pkt_cnt
`endif
);
    state_e            state_q, state_d;
    logic [AW_DEV-1:0] src_q, src_d;
    logic [AW_DEV-1:0] dest_q, dest_d;
    logic [AW_DEV-1:0] ptr_q, ptr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [DW-1:0]     fifo_q, fifo_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [N-1:0]      wen_q, wen_d;
    logic [N-1:0]      arb_oh;
    logic [AW_DEV-1:0] arb_idx;

    rr_arb #(.AW(AW_DEV), .N(N)) u_arb (
        .rqt    (rqt),
        .ptr    (ptr_q),
        .gnt_oh (arb_oh),
        .idx    (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dest_d  = dest_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        fifo_d  = fifo_q;
        gnt_d   = gnt_q;
        wen_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (|rqt) begin
                    src_d   = arb_idx;
                    dest_d  = adr_i[arb_idx*AW_DEV +: AW_DEV];
                    data_d  = dat_i[arb_idx*DW +: DW];
                    gnt_d   = arb_oh;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!full_array[dest_q]) begin
                    wen_d   = N'(1) << dest_q;
                    fifo_d  = data_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!validtx[src_q]) begin
                    gnt_d   = '0;
                    ptr_d   = src_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            src_q   <= '0;
            dest_q  <= '0;
            ptr_q   <= AW_DEV'(N - 1);
            data_q  <= '0;
            fifo_q  <= '0;
            gnt_q   <= '0;
            wen_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dest_q  <= dest_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            fifo_q  <= fifo_d;
            gnt_q   <= gnt_d;
            wen_q   <= wen_d;
        end
    end

    assign gnt    = gnt_q;
    assign wen    = wen_q;
    assign fifo_o = fifo_q;

`ifdef SWITCH_CORE_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (|wen_q) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign pkt_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_switch_core.sv
// Directed bench for switch_core with the default 4-port, 4-bit configuration.
module tb_switch_core;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  rqt, validtx, full_array;
    logic [15:0] dat_i;
    logic [7:0]  adr_i;
    logic [3:0]  gnt, wen, fifo_o;
`ifdef SWITCH_CORE_STATS_EN
    logic [15:0] pkt_cnt;
`endif
    int checks = 0;
    int fails  = 0;

    switch_core dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rqt        (rqt),
        .validtx    (validtx),
        .dat_i      (dat_i),
        .adr_i      (adr_i),
        .full_array (full_array),
        .gnt        (gnt),
        .fifo_o     (fifo_o),
        .wen        (wen)
`ifdef SWITCH_CORE_STATS_EN
        ,
        .pkt_cnt    (pkt_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; rqt = '0; validtx = '0; full_array = '0; dat_i = '0; adr_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        checks++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (wen !== 4'b0000) begin fails++; $display("FAIL reset_wen: got %b expected 0000", wen); end
        checks++; if (fifo_o !== 4'h0) begin fails++; $display("FAIL reset_fifo: got %h expected 0", fifo_o); end
        tick();
        checks++; if (gnt !== 4'b0000 || wen !== 4'b0000) begin fails++; $display("FAIL idle_quiet: got gnt %b wen %b expected 0000/0000", gnt, wen); end
    endtask

    task automatic test_single();
        rqt = 4'b0001; validtx = 4'b0001; adr_i[1:0] = 2'd2; dat_i[3:0] = 4'hA;
        tick();
        checks++; if (gnt !== 4'b0001) begin fails++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
        checks++; if (wen !== 4'b0000) begin fails++; $display("FAIL single_wen_early: got %b expected 0000", wen); end
        rqt = '0;
        tick();
        checks++; if (wen !== 4'b0100) begin fails++; $display("FAIL single_wen: got %b expected 0100", wen); end
        checks++; if (fifo_o !== 4'hA) begin fails++; $display("FAIL single_fifo: got %h expected a", fifo_o); end
        validtx = '0;
        tick();
        checks++; if (wen !== 4'b0000) begin fails++; $display("FAIL single_wen_pulse: got %b expected 0000", wen); end
        checks++; if (gnt !== 4'b0000) begin fails++; $display("FAIL single_gnt_drop: got %b expected 0000", gnt); end
        checks++; if (fifo_o !== 4'hA) begin fails++; $display("FAIL single_fifo_hold: got %h expected a", fifo_o); end
    endtask

    task automatic test_round_robin();
        int n;
        logic [3:0] eg, ew, ed;
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        adr_i = {2'd0, 2'd3, 2'd2, 2'd1};
        dat_i = {4'h4, 4'h3, 4'h2, 4'h1};
        rqt = 4'hF; validtx = 4'hF;
        for (int t = 0; t < 5; t++) begin
            eg = 4'b0001 << (t % 4);
            ew = 4'b0001 << ((t + 1) % 4);
            ed = 4'((t % 4) + 1);
            n = 0;
            while (gnt === 4'b0000 && n < 10) begin tick(); n++; end
            checks++; if (gnt !== eg) begin fails++; $display("FAIL rr_gnt%0d: got %b expected %b", t, gnt, eg); end
            tick();
            checks++; if (wen !== ew) begin fails++; $display("FAIL rr_wen%0d: got %b expected %b", t, wen, ew); end
            checks++; if (fifo_o !== ed) begin fails++; $display("FAIL rr_fifo%0d: got %h expected %h", t, fifo_o, ed); end
            tick(); tick();
            validtx[t % 4] = 1'b0;
            tick();
            checks++; if (gnt !== 4'b0000) begin fails++; $display("FAIL rr_drop%0d: got %b expected 0000", t, gnt); end
            checks++; if (wen !== 4'b0000) begin fails++; $display("FAIL rr_wen_off%0d: got %b expected 0000", t, wen); end
            validtx[t % 4] = 1'b1;
        end
        rqt = '0; validtx = '0;
        tick();
    endtask

    task automatic test_full();
        full_array = 4'b0100;
        rqt = 4'b0010; validtx = 4'b0010; adr_i[3:2] = 2'd2; dat_i[7:4] = 4'h5;
        tick();
        checks++; if (gnt !== 4'b0010) begin fails++; $display("FAIL full_gnt: got %b expected 0010", gnt); end
        rqt = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (wen !== 4'b0000) begin fails++; $display("FAIL full_stall%0d: got %b expected 0000", i, wen); end
            checks++; if (gnt !== 4'b0010) begin fails++; $display("FAIL full_gnt_hold%0d: got %b expected 0010", i, gnt); end
        end
        full_array = '0;
        tick();
        checks++; if (wen !== 4'b0100) begin fails++; $display("FAIL full_release_wen: got %b expected 0100", wen); end
        checks++; if (fifo_o !== 4'h5) begin fails++; $display("FAIL full_release_fifo: got %h expected 5", fifo_o); end
        validtx = '0;
        tick();
        checks++; if (wen !== 4'b0000 || gnt !== 4'b0000) begin fails++; $display("FAIL full_done: got gnt %b wen %b expected 0000/0000", gnt, wen); end
    endtask

    task automatic test_hold();
        adr_i[7:6] = 2'd3; dat_i[15:12] = 4'hC;
        adr_i[1:0] = 2'd0; dat_i[3:0] = 4'h7;
        rqt = 4'b1000; validtx = 4'b1000;
        tick();
        checks++; if (gnt !== 4'b1000) begin fails++; $display("FAIL hold_gnt: got %b expected 1000", gnt); end
        rqt = 4'b0001;
        tick();
        checks++; if (wen !== 4'b1000) begin fails++; $display("FAIL self_wen: got %b expected 1000", wen); end
        checks++; if (fifo_o !== 4'hC) begin fails++; $display("FAIL self_fifo: got %h expected c", fifo_o); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (gnt !== 4'b1000) begin fails++; $display("FAIL hold_gnt%0d: got %b expected 1000", i, gnt); end
            checks++; if (wen !== 4'b0000) begin fails++; $display("FAIL hold_wen%0d: got %b expected 0000", i, wen); end
        end
        validtx = '0;
        tick();
        checks++; if (gnt !== 4'b0000) begin fails++; $display("FAIL hold_drop: got %b expected 0000", gnt); end
        tick();
        checks++; if (gnt !== 4'b0001) begin fails++; $display("FAIL late_rqt_gnt: got %b expected 0001", gnt); end
        rqt = '0;
        tick();
        checks++; if (wen !== 4'b0001) begin fails++; $display("FAIL late_rqt_wen: got %b expected 0001", wen); end
        checks++; if (fifo_o !== 4'h7) begin fails++; $display("FAIL late_rqt_fifo: got %h expected 7", fifo_o); end
        tick();
        checks++; if (gnt !== 4'b0000) begin fails++; $display("FAIL late_rqt_drop: got %b expected 0000", gnt); end
    endtask

    task automatic test_reset_mid();
        full_array = 4'b0010;
        rqt = 4'b0100; validtx = 4'b0100; adr_i[5:4] = 2'd1; dat_i[11:8] = 4'h9;
        tick();
        checks++; if (gnt !== 4'b0100) begin fails++; $display("FAIL mid_gnt: got %b expected 0100", gnt); end
        rqt = '0;
        tick();
        checks++; if (wen !== 4'b0000) begin fails++; $display("FAIL mid_stall: got %b expected 0000", wen); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; full_array = '0; validtx = '0;
        checks++; if (gnt !== 4'b0000) begin fails++; $display("FAIL mid_rst_gnt: got %b expected 0000", gnt); end
        checks++; if (wen !== 4'b0000) begin fails++; $display("FAIL mid_rst_wen: got %b expected 0000", wen); end
        checks++; if (fifo_o !== 4'h0) begin fails++; $display("FAIL mid_rst_fifo: got %h expected 0", fifo_o); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (wen !== 4'b0000 || gnt !== 4'b0000) begin fails++; $display("FAIL mid_aborted%0d: got gnt %b wen %b expected 0000/0000", i, gnt, wen); end
        end
        rqt = 4'hF;
        tick();
        checks++; if (gnt !== 4'b0001) begin fails++; $display("FAIL mid_next_gnt: got %b expected 0001", gnt); end
        rqt = '0;
        tick(); tick(); tick();
        checks++; if (gnt !== 4'b0000) begin fails++; $display("FAIL mid_drain: got %b expected 0000", gnt); end
`ifdef SWITCH_CORE_STATS_EN
        checks++; if (pkt_cnt !== 16'd1) begin fails++; $display("FAIL pkt_cnt: got %0d expected 1", pkt_cnt); end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/switch_core.md
SWITCH_CORE -- requirements
Module: switch_core

Interface
REQ-001 The block SHALL have parameter AW_DEV, default 2, meaning the destination address width; the port count is N = 1<<AW_DEV.
REQ-002 The block SHALL have parameter DW, default 4, meaning the data width.
REQ-003 The block SHALL have port clk_i, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit, meaning the reset; it is synchronous and active-high.
REQ-005 The block SHALL have port rqt, input, N bits, meaning the per-port request (validtx already qualified by destination not full).
REQ-006 The block SHALL have port validtx, input, N bits, meaning the per-port 4-phase valid.
REQ-007 The block SHALL have port dat_i, input, N*DW bits, meaning the flattened source data; port k occupies [k*DW +: DW].
REQ-008 The block SHALL have port adr_i, input, N*AW_DEV bits, meaning the flattened destination address; port k occupies [k*AW_DEV +: AW_DEV].
REQ-009 The block SHALL have port full_array, input, N bits, meaning the per-port output FIFO full flag.
REQ-010 The block SHALL have port gnt, output, N bits, meaning the one-hot grant to the source port.
REQ-011 The block SHALL have port fifo_o, output, DW bits, meaning the shared write data bus to all port FIFOs.
REQ-012 The block SHALL have port wen, output, N bits, meaning the one-hot FIFO write enable to the destination port.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The state machine SHALL have exactly three states: IDLE, WRITE and HOLD.
REQ-015 In IDLE with |rqt=1, the next edge SHALL perform all of the following:
- choose src by round-robin, starting the search at ptr+1 modulo N;
- latch src, dest = adr_i[src] and data = dat_i[src];
- set gnt to onehot(src);
- go to WRITE.
REQ-016 In IDLE with rqt=0, gnt and wen SHALL remain 0.
REQ-017 In WRITE with full_array[dest]=0, the next edge SHALL set wen to onehot(dest), set fifo_o to data, and go to HOLD.
REQ-018 In WRITE with full_array[dest]=1, the block SHALL stay in WRITE with wen=0 until the destination is not full.
REQ-019 wen SHALL be high for exactly one cycle per transfer and SHALL be cleared on the first HOLD edge.
REQ-020 In HOLD, gnt SHALL stay asserted while validtx[src]=1.
REQ-021 In HOLD with validtx[src]=0, the next edge SHALL set gnt=0, set ptr=src, and go to IDLE.
REQ-022 Latency from rqt high in IDLE to gnt high SHALL be 1 cycle, and to wen high SHALL be 2 cycles when the destination is not full.
REQ-023 At most one transfer SHALL be in flight at any time.
REQ-024 Requests arriving outside IDLE SHALL be ignored until the next return to IDLE.
REQ-025 Simultaneous requests SHALL be served one per transaction in round-robin order; each requester is served within N transactions.
REQ-026 A self-addressed transfer (dest == src) SHALL be legal and handled identically to any other transfer.
REQ-027 fifo_o SHALL hold its last written value when wen=0.

Reset
REQ-028 With rst_i=1, the next edge SHALL set state=IDLE, gnt=0, wen=0, fifo_o=0 and ptr=N-1, so port 0 has first priority.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer, and no wen pulse SHALL be issued after the reset edge.

Configuration
REQ-030 With macro SWITCH_CORE_STATS_EN defined, the block SHALL add output pkt_cnt, 16 bits, reset to 0, incremented on every cycle with |wen=1, and wrapping from 16'hFFFF to 0.
REQ-031 With SWITCH_CORE_STATS_EN undefined, the block SHALL have no pkt_cnt port and no counter logic.

Structure
REQ-032 A shared package switch_pkg SHALL hold the state enumeration {IDLE, WRITE, HOLD} and the default AW_DEV and DW constants.
REQ-033 The round-robin selection (rqt and ptr in, one-hot and index out, combinational) SHALL be a sub-module named rr_arb.
REQ-034 The FSM and the datapath registers SHALL reside in switch_core.

Verification
REQ-035 Reset then rqt=4'b0001, adr_i[0]=2, dat_i[0]=4'hA -> gnt=0001 at +1 cycle; wen=0100 with fifo_o=A at +2 cycles for exactly 1 cycle.
REQ-036 rqt=4'b1111 held, each port drops validtx 3 cycles after its grant -> grant order 0,1,2,3,0.
REQ-037 full_array[2]=1 while in WRITE with dest=2 -> wen stays 0; when full_array[2] clears, wen=0100 on the next edge.
REQ-038 validtx[src] held high 10 cycles after the write -> gnt stays high 10 cycles with no further wen; gnt drops 1 cycle after validtx falls.
REQ-039 rst_i pulsed while in WRITE -> gnt=0, wen=0 and state=IDLE; the next grant goes to port 0 when rqt=1111.
REQ-040 With SWITCH_CORE_STATS_EN defined, 65537 transfers -> pkt_cnt=1.
